redirect_ctrl: RTL and testbench

Pipeline control-flow sequencer for the 5-stage MIPS core. It arbitrates the three sources of fetch redirection: taken branches resolved in EX, external interrupt entry, and ERET return. It also owns the interrupt-state registers EPC, EXL and cause. It sits beside the EX-stage branch resolver, consumes its BranchEx result, and drives the PC-select and stage-flush controls.

---
 rtl/redirect_ctrl_pkg.sv | 13 +
 rtl/redirect_ctrl_int_prio_enc.sv | 24 ++
 rtl/redirect_ctrl.sv | 132 +++++++++++++
 tb/tb_redirect_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/redirect_ctrl_pkg.sv
// Shared state encodings and defaults for the fetch-redirect sequencer.
package redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RETURN  = 2'd2
  } redir_state_e;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0800;
  localparam int          CAUSE_W              = 3;

endpackage

// File: rtl/redirect_ctrl_int_prio_enc.sv
// Interrupt priority encoder: the lowest-index asserted request wins.
module int_prio_enc
  import redirect_ctrl_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic [LINES-1:0]   req_i,
  output logic [CAUSE_W-1:0] idx_o,
  output logic               vld_o
);

  // Scan downward so the last hit, i.e. the lowest index, is what remains.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = CAUSE_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Fetch redirection sequencer: taken branches, interrupt entry and ERET return.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction and tag it in EX.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter int          INT_LINES    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BranchEx,
  input  logic [31:0]          BranchTargetEx,
  input  logic [31:0]          PCEx,
  input  logic                 ValidEx,
  input  logic                 EretEx,
  input  logic                 StallPipe,
  input  logic [INT_LINES-1:0] IntReq,
  output logic                 RedirectEn,
  output logic [31:0]          RedirectPC,
  output logic                 FlushIf,
  output logic                 FlushId,
  output logic                 FlushEx,
  output logic                 IntAck,
  output logic [CAUSE_W-1:0]   IntCause,
  output logic [31:0]          Epc,
  output logic                 Exl
);

  redir_state_e         st_q, st_d;
  logic [INT_LINES-1:0] pend_q, pend_d, ack_mask;
  logic [31:0]          epc_q, epc_d;
  logic                 exl_q, exl_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic                 ds_q, ds_d;
  logic [CAUSE_W-1:0]   prio_idx;
  logic                 prio_vld;
  logic                 br_take, safe_point;

  int_prio_enc #(.LINES(INT_LINES)) u_prio (
    .req_i (pend_q),
    .idx_o (prio_idx),
    .vld_o (prio_vld)
  );

  assign br_take    = BranchEx & ValidEx;
  assign safe_point = ValidEx & ~StallPipe & ~BranchEx & ~EretEx & ~ds_q;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic BR_FLUSH_ID = 1'b0;

  // The instruction following a taken branch into EX is the delay slot.
  assign ds_d = br_take & ~StallPipe;

  always_ff @(posedge clk) begin
    if (rst) ds_q <= 1'b0;
    else     ds_q <= ds_d;
  end
`else
  localparam logic BR_FLUSH_ID = 1'b1;

  assign ds_d = 1'b0;
  assign ds_q = ds_d;
`endif

  always_comb begin
    st_d       = st_q;
    epc_d      = epc_q;
    exl_d      = exl_q;
    cause_d    = cause_q;
    ack_mask   = '0;
    RedirectEn = 1'b0;
    RedirectPC = '0;
    FlushIf    = 1'b0;
    FlushId    = 1'b0;
    FlushEx    = 1'b0;
    IntAck     = 1'b0;

    if (!rst) begin
      if (br_take) begin
        RedirectEn = 1'b1;
        RedirectPC = BranchTargetEx;
        FlushIf    = 1'b1;
        FlushId    = BR_FLUSH_ID;
      end else if (st_q == ST_RUN && prio_vld && safe_point && !exl_q) begin
        RedirectEn = 1'b1;
        RedirectPC = HANDLER_ADDR;
        FlushIf    = 1'b1;
        FlushId    = 1'b1;
        FlushEx    = 1'b1;
        IntAck     = 1'b1;
        ack_mask   = INT_LINES'(1) << prio_idx;
        epc_d      = PCEx;
        exl_d      = 1'b1;
        cause_d    = prio_idx;
        st_d       = ST_HANDLER;
      end else if (st_q == ST_HANDLER && EretEx && ValidEx) begin
        RedirectEn = 1'b1;
        RedirectPC = epc_q;
        FlushIf    = 1'b1;
        FlushId    = 1'b1;
        exl_d      = 1'b0;
        st_d       = ST_RETURN;
      end

      // The restarted instruction reaching EX reopens the interrupt window.
      if (st_q == ST_RETURN && ValidEx) st_d = ST_RUN;
    end

    pend_d = (pend_q | IntReq) & ~ack_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_RUN;
      pend_q  <= '0;
      epc_q   <= '0;
      exl_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      st_q    <= st_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
      cause_q <= cause_d;
    end
  end

  assign Epc      = epc_q;
  assign Exl      = exl_q;
  assign IntCause = cause_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_redirect_ctrl;

  localparam int          NL    = 4;
  localparam logic [31:0] HADDR = 32'h0000_0800;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS_MODE = 1'b1;
`else
  localparam bit DS_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          BranchEx = 1'b0, ValidEx = 1'b0, EretEx = 1'b0, StallPipe = 1'b0;
  logic [31:0]   BranchTargetEx = '0, PCEx = '0;
  logic [NL-1:0] IntReq = '0;
  logic          RedirectEn, FlushIf, FlushId, FlushEx, IntAck, Exl;
  logic [31:0]   RedirectPC, Epc;
  logic [2:0]    IntCause;

  always #5 clk = ~clk;

  redirect_ctrl #(.HANDLER_ADDR(HADDR), .INT_LINES(NL)) dut (
    .clk            (clk),
    .rst            (rst),
    .BranchEx       (BranchEx),
    .BranchTargetEx (BranchTargetEx),
    .PCEx           (PCEx),
    .ValidEx        (ValidEx),
    .EretEx         (EretEx),
    .StallPipe      (StallPipe),
    .IntReq         (IntReq),
    .RedirectEn     (RedirectEn),
    .RedirectPC     (RedirectPC),
    .FlushIf        (FlushIf),
    .FlushId        (FlushId),
    .FlushEx        (FlushEx),
    .IntAck         (IntAck),
    .IntCause       (IntCause),
    .Epc            (Epc),
    .Exl            (Exl)
  );

  typedef struct packed {
    logic        ren;
    logic [31:0] rpc;
    logic        fif;
    logic        fid;
    logic        fex;
    logic        ack;
    logic [2:0]  cause;
    logic [31:0] epc;
    logic        exl;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: processor mode flags and interrupt bookkeeping.
  bit          m_handler, m_returning, m_exl, m_ds;
  logic [NL-1:0] m_pend;
  logic [31:0] m_epc;
  logic [2:0]  m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_cycle();
    obs_t          e;
    logic [NL-1:0] ack;
    bit            taken, accept, was_returning;
    int            win;
    e       = '0;
    ack     = '0;
    e.epc   = m_epc;
    e.exl   = m_exl;
    e.cause = m_cause;
    if (rst) begin
      m_handler = 0; m_returning = 0; m_exl = 0; m_ds = 0;
      m_pend = '0; m_epc = '0; m_cause = '0;
    end else begin
      taken         = BranchEx && ValidEx;
      was_returning = m_returning;
      win           = -1;
      for (int i = 0; i < NL; i++) if (m_pend[i] && win < 0) win = i;
      accept = !taken && !m_handler && !m_returning && !m_exl && (win >= 0) &&
               ValidEx && !StallPipe && !BranchEx && !EretEx && !m_ds;
      if (taken) begin
        e.ren = 1; e.rpc = BranchTargetEx; e.fif = 1; e.fid = !DS_MODE;
      end else if (accept) begin
        e.ren = 1; e.rpc = HADDR; e.fif = 1; e.fid = 1; e.fex = 1; e.ack = 1;
        ack[win]  = 1'b1;
        m_epc     = PCEx;
        m_exl     = 1;
        m_cause   = 3'(win);
        m_handler = 1;
      end else if (m_handler && EretEx && ValidEx) begin
        e.ren = 1; e.rpc = m_epc; e.fif = 1; e.fid = 1;
        m_exl       = 0;
        m_handler   = 0;
        m_returning = 1;
      end
      if (was_returning && ValidEx) m_returning = 0;
      m_ds   = DS_MODE && taken && !StallPipe;
      m_pend = (m_pend | IntReq) & ~ack;
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit br, input logic [31:0] tgt, input bit v,
                       input logic [31:0] pc, input bit er, input bit st,
                       input logic [NL-1:0] rq);
    @(posedge clk);
    #1;
    rst = r; BranchEx = br; BranchTargetEx = tgt; ValidEx = v;
    PCEx = pc; EretEx = er; StallPipe = st; IntReq = rq;
    model_cycle();
    #1;
  endtask

  // Monitor: every cycle the outputs are compared with the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {RedirectEn, RedirectPC, FlushIf, FlushId, FlushEx, IntAck, IntCause, Epc, Exl};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got ren=%b pc=%h fl=%b%b%b ack=%b cause=%0d epc=%h exl=%b expected ren=%b pc=%h fl=%b%b%b ack=%b cause=%0d epc=%h exl=%b",
                   $time, a.ren, a.rpc, a.fif, a.fid, a.fex, a.ack, a.cause, a.epc, a.exl,
                   e.ren, e.rpc, e.fif, e.fid, e.fex, e.ack, e.cause, e.epc, e.exl);
        end
      end
    end
  end

  initial begin
    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 1, 32'h10, 1, 0, 4'b1111);
    chk("rst_ren", RedirectEn, 0);
    chk("rst_epc", Epc, 0);
    chk("rst_exl", Exl, 0);
    chk("rst_cause", IntCause, 0);

    // Branch in RUN
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 1, 32'h40, 1, 32'h1000, 0, 0, '0);
    chk("br_ren", RedirectEn, 1);
    chk("br_pc", RedirectPC, 32'h40);
    chk("br_fif", FlushIf, 1);
    chk("br_fid", FlushId, !DS_MODE);
    chk("br_fex", FlushEx, 0);

    // Interrupt entry
    drive(0, 0, 0, 0, 0, 0, 0, 4'b0100);
    drive(0, 0, 0, 1, 32'h120, 0, 0, '0);
    chk("int_pc", RedirectPC, 32'h800);
    chk("int_ack", IntAck, 1);
    chk("int_flush", {FlushIf, FlushId, FlushEx}, 3'b111);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    chk("int_epc", Epc, 32'h120);
    chk("int_exl", Exl, 1);
    chk("int_cause", IntCause, 2);

    // Masking in handler, ERET and return window
    drive(0, 0, 0, 1, 32'h130, 0, 0, 4'b0011);
    chk("mask_ack0", IntAck, 0);
    drive(0, 0, 0, 1, 32'h134, 0, 0, '0);
    chk("mask_ack1", IntAck, 0);
    drive(0, 0, 0, 1, 32'h138, 1, 0, '0);
    chk("eret_ren", RedirectEn, 1);
    chk("eret_pc", RedirectPC, 32'h120);
    drive(0, 0, 0, 1, 32'h120, 0, 0, '0);
    chk("ret_exl", Exl, 0);
    chk("ret_ack_blocked", IntAck, 0);
    drive(0, 0, 0, 1, 32'h124, 0, 0, '0);
    chk("ret_ack", IntAck, 1);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    chk("ret_cause", IntCause, 0);

    // Branch and pending interrupt in the same cycle
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 4'b0001);
    drive(0, 1, 32'h200, 1, 32'h100, 0, 0, '0);
    chk("cf_pc", RedirectPC, 32'h200);
    chk("cf_ack", IntAck, 0);
    drive(0, 0, 0, 1, 32'h104, 0, 0, '0);
    chk("cf_ack_slot", IntAck, !DS_MODE);
    drive(0, 0, 0, 1, 32'h200, 0, 0, '0);
    chk("cf_ack_late", IntAck, DS_MODE);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    chk("cf_epc", Epc, DS_MODE ? 32'h200 : 32'h104);

    // Stall blocking
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 32'h2fc, 0, 1, '0);
      chk("stall_ack", IntAck, 0);
    end
    drive(0, 0, 0, 1, 32'h300, 0, 0, '0);
    chk("stall_go", IntAck, 1);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    chk("stall_cause", IntCause, 3);

    // Reset mid-handler
    drive(1, 0, 0, 1, 32'h304, 1, 0, 4'b0101);
    chk("rsth_ren", RedirectEn, 0);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    chk("rsth_exl", Exl, 0);
    chk("rsth_epc", Epc, 0);
    drive(0, 0, 0, 1, 32'h500, 1, 0, '0);
    chk("rsth_eret", RedirectEn, 0);
    drive(0, 0, 0, 1, 32'h504, 0, 0, '0);
    chk("rsth_pend", IntAck, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 6) == 0, $urandom,
            $urandom_range(0, 4) != 0, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            ($urandom_range(0, 7) == 0) ? NL'($urandom) : '0);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
